issue_buffer: RTL and testbench

Parametrised in-order issue buffer between decode and the scoreboard. It accepts up to WR_PORTS decoded instructions per cycle and presents up to RD_PORTS of the oldest entries per cycle for issue. A control-flow entry serialises the issue group: nothing younger than it issues in the same cycle. It generalises the single-entry staging of the current issue path to configurable depth and width, with flush and occupancy reporting.

---
 rtl/issue_buffer_pkg.sv | 20 ++
 rtl/issue_buffer_lzc.sv | 23 ++
 rtl/issue_buffer.sv | 143 ++++++++++++++
 tb/tb_issue_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_buffer_pkg.sv
// Shared defaults and circular-index helper for the in-order issue buffer.
package issue_buffer_pkg;

    localparam int unsigned IB_DEPTH_DEFAULT      = 8;
    localparam int unsigned IB_WR_PORTS_DEFAULT   = 2;
    localparam int unsigned IB_RD_PORTS_DEFAULT   = 2;
    localparam int unsigned IB_DATA_WIDTH_DEFAULT = 64;

    // Offsets never exceed depth-1, so one conditional subtract is enough for any depth.
    function automatic int unsigned ib_wrap(
        input int unsigned base,
        input int unsigned off,
        input int unsigned depth
    );
        int unsigned sum;
        sum = base + off;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/issue_buffer_lzc.sv
// Counts zeros from bit 0 up to the first set bit; returns WIDTH when the vector is all zero.
module issue_buffer_lzc #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] w_cnt;

    always_comb begin
        w_cnt = CNT_W'(WIDTH);
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                w_cnt = CNT_W'(i);
            end
        end
    end

    assign cnt_o = w_cnt;

endmodule

// File: rtl/issue_buffer.sv
// In-order multi-port issue buffer: accepts up to WR_PORTS entries per cycle and presents the
// oldest RD_PORTS for issue, with control-flow entries closing the issue group behind them.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = IB_DEPTH_DEFAULT,
    parameter int unsigned WR_PORTS   = IB_WR_PORTS_DEFAULT,
    parameter int unsigned RD_PORTS   = IB_RD_PORTS_DEFAULT,
    parameter int unsigned DATA_WIDTH = IB_DATA_WIDTH_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] enq_data_i,
    input  logic [WR_PORTS-1:0]            enq_valid_i,
    input  logic [WR_PORTS-1:0]            enq_ctrl_flow_i,
    output logic [WR_PORTS-1:0]            enq_ack_o,
    output logic [RD_PORTS*DATA_WIDTH-1:0] deq_data_o,
    output logic [RD_PORTS-1:0]            deq_ctrl_flow_o,
    output logic [RD_PORTS-1:0]            deq_valid_o,
    input  logic [RD_PORTS-1:0]            deq_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WR_CW = $clog2(WR_PORTS + 1);
    localparam int unsigned RD_CW = $clog2(RD_PORTS + 1);

    if (DEPTH < 2 || DEPTH < WR_PORTS || DEPTH < RD_PORTS) begin : g_param_check
        $error("issue_buffer: DEPTH must be >= 2 and >= max(WR_PORTS, RD_PORTS)");
    end

    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic                  r_mem_ctrl [DEPTH];
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_wptr;
    logic [CNT_W-1:0]      r_count;

    logic [PTR_W-1:0]      w_wr_idx [WR_PORTS];
    logic [PTR_W-1:0]      w_rd_idx [RD_PORTS];
    logic [RD_PORTS-1:0]   w_blocked;
    logic [WR_CW-1:0]      w_enq_run;
    logic [RD_CW-1:0]      w_ack_run;
    logic [CNT_W-1:0]      w_free;
    logic [CNT_W-1:0]      w_accepted;
    logic [CNT_W-1:0]      w_popped;
    logic [RD_PORTS-1:0]   w_ack_masked;
    logic [RD_PORTS-1:0]   w_ack_plus1;
    logic                  w_ack_legal;
    logic [PTR_W-1:0]      w_rptr_next;
    logic [PTR_W-1:0]      w_wptr_next;
    logic [CNT_W-1:0]      w_count_next;

    // Length of the contiguous valid run starting at enqueue port 0.
    issue_buffer_lzc #(.WIDTH(WR_PORTS)) u_enq_run (
        .in_i  (~enq_valid_i),
        .cnt_o (w_enq_run)
    );

    // Number of leading consumed entries, restricted to what is actually presented.
    issue_buffer_lzc #(.WIDTH(RD_PORTS)) u_deq_run (
        .in_i  (~w_ack_masked),
        .cnt_o (w_ack_run)
    );

    // Room is judged on registered occupancy only, so same-cycle pops never unlock an enqueue.
    assign w_free = CNT_W'(DEPTH) - r_count;

    always_comb begin
        w_accepted = '0;
        if (!flush_i && !rst_i) begin
            w_accepted = (CNT_W'(w_enq_run) < w_free) ? CNT_W'(w_enq_run) : w_free;
        end
    end

    for (genvar gi = 0; gi < int'(WR_PORTS); gi++) begin : g_enq
        assign w_wr_idx[gi]  = PTR_W'(ib_wrap(32'(r_wptr), 32'(gi), DEPTH));
        assign enq_ack_o[gi] = (CNT_W'(gi) < w_accepted);
    end

    for (genvar gi = 0; gi < int'(RD_PORTS); gi++) begin : g_deq
        assign w_rd_idx[gi] = PTR_W'(ib_wrap(32'(r_rptr), 32'(gi), DEPTH));
        assign deq_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_mem_data[w_rd_idx[gi]];
        assign deq_ctrl_flow_o[gi] = r_mem_ctrl[w_rd_idx[gi]];

        // A control-flow entry at any older read port closes the group for this one.
        if (gi == 0) begin : g_head
            assign w_blocked[gi] = 1'b0;
        end else begin : g_tail
            assign w_blocked[gi] = w_blocked[gi-1] | deq_ctrl_flow_o[gi-1];
        end

        assign deq_valid_o[gi] = (CNT_W'(gi) < r_count) & ~w_blocked[gi];
    end

    assign w_ack_masked = deq_ack_i & deq_valid_o;
    assign w_popped     = flush_i ? '0 : CNT_W'(w_ack_run);

    assign w_rptr_next  = flush_i ? '0 : PTR_W'(ib_wrap(32'(r_rptr), 32'(w_popped), DEPTH));
    assign w_wptr_next  = flush_i ? '0 : PTR_W'(ib_wrap(32'(r_wptr), 32'(w_accepted), DEPTH));
    assign w_count_next = flush_i ? '0 : (r_count + w_accepted - w_popped);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                r_mem_data[e] <= '0;
                r_mem_ctrl[e] <= 1'b0;
            end
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < int'(WR_PORTS); k++) begin
                if (enq_ack_o[k]) begin
                    r_mem_data[w_wr_idx[k]] <= enq_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    r_mem_ctrl[w_wr_idx[k]] <= enq_ctrl_flow_i[k];
                end
            end
            r_rptr  <= w_rptr_next;
            r_wptr  <= w_wptr_next;
            r_count <= w_count_next;
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);

    // Acks must form a contiguous run from port 0 inside the presented window.
    assign w_ack_plus1 = deq_ack_i + RD_PORTS'(1);
    assign w_ack_legal = ((deq_ack_i & ~deq_valid_o) == '0) &&
                         ((deq_ack_i & w_ack_plus1) == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && (r_count != '0)) begin
            assert (w_ack_legal);
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Directed self-checking bench for issue_buffer with the default 8x2x2x64 configuration.
module tb_issue_buffer;

    localparam int DEPTH = 8;
    localparam int WR    = 2;
    localparam int RD    = 2;
    localparam int DW    = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [WR*DW-1:0] enq_data;
    logic [WR-1:0]    enq_valid;
    logic [WR-1:0]    enq_ctrl;
    logic [WR-1:0]    enq_ack;
    logic [RD*DW-1:0] deq_data;
    logic [RD-1:0]    deq_ctrl;
    logic [RD-1:0]    deq_valid;
    logic [RD-1:0]    deq_ack;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    issue_buffer #(
        .DEPTH      (DEPTH),
        .WR_PORTS   (WR),
        .RD_PORTS   (RD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .enq_data_i      (enq_data),
        .enq_valid_i     (enq_valid),
        .enq_ctrl_flow_i (enq_ctrl),
        .enq_ack_o       (enq_ack),
        .deq_data_o      (deq_data),
        .deq_ctrl_flow_o (deq_ctrl),
        .deq_valid_o     (deq_valid),
        .deq_ack_i       (deq_ack),
        .count_o         (count),
        .full_o          (full),
        .empty_o         (empty)
    );

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enq_valid = 2'b11;
        enq_data  = {64'hA1, 64'hA0};
        repeat (2) cycle();
        settle();
        vectors++; if (enq_ack !== 2'b00) begin errors++; $display("FAIL reset_enq_ack: got %b expected 00", enq_ack); end
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
        vectors++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL reset_deq_valid: got %b expected 00", deq_valid); end
        vectors++; if (deq_data !== '0 || deq_ctrl !== 2'b00) begin errors++; $display("FAIL reset_deq_data: got %h/%b expected 0", deq_data, deq_ctrl); end
        rst = 1'b0;
        settle();
        vectors++; if (enq_ack !== 2'b11) begin errors++; $display("FAIL release_enq_ack: got %b expected 11", enq_ack); end
        cycle();
        enq_valid = 2'b00;
        settle();
        vectors++; if (count !== 4'd2) begin errors++; $display("FAIL release_count: got %0d expected 2", count); end
        vectors++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL release_deq_valid: got %b expected 11", deq_valid); end
        vectors++; if (deq_data !== {64'hA1, 64'hA0}) begin errors++; $display("FAIL release_deq_data: got %h expected a1/a0", deq_data); end
        $display("test_reset: count=%0d deq_valid=%b", count, deq_valid);
        do_flush();
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 2'b11;
            enq_data  = {64'(2*i + 2), 64'(2*i + 1)};
            settle();
            vectors++; if (enq_ack !== 2'b11) begin errors++; $display("FAIL fill_ack[%0d]: got %b expected 11", i, enq_ack); end
            cycle();
        end
        settle();
        vectors++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1/8", full, count); end
        vectors++; if (enq_ack !== 2'b00) begin errors++; $display("FAIL fill_refuse: got %b expected 00", enq_ack); end
        vectors++; if (deq_data !== {64'd2, 64'd1}) begin errors++; $display("FAIL fill_head: got %h expected 2/1", deq_data); end
        deq_ack = 2'b11;
        settle();
        vectors++; if (enq_ack !== 2'b00) begin errors++; $display("FAIL full_pop_refuse: got %b expected 00", enq_ack); end
        cycle();
        deq_ack   = 2'b00;
        enq_valid = 2'b00;
        settle();
        vectors++; if (count !== 4'd6 || full !== 1'b0) begin errors++; $display("FAIL full_pop_count: got %0d full=%b expected 6/0", count, full); end
        vectors++; if (deq_data !== {64'd4, 64'd3}) begin errors++; $display("FAIL full_pop_data: got %h expected 4/3", deq_data); end
        $display("test_fill_full: count=%0d", count);
    endtask

    task automatic test_gap();
        enq_valid = 2'b10;
        settle();
        vectors++; if (enq_ack !== 2'b00) begin errors++; $display("FAIL gap_ack: got %b expected 00", enq_ack); end
        cycle();
        enq_valid = 2'b00;
        settle();
        vectors++; if (count !== 4'd6) begin errors++; $display("FAIL gap_count: got %0d expected 6", count); end
        $display("test_gap: count=%0d", count);
        do_flush();
    endtask

    task automatic test_ctrl_flow();
        enq_valid = 2'b11;
        enq_ctrl  = 2'b01;
        enq_data  = {64'hBB, 64'hAA};
        cycle();
        enq_valid = 2'b00;
        enq_ctrl  = 2'b00;
        settle();
        vectors++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL ctrl_serialise: got %b expected 01", deq_valid); end
        vectors++; if (deq_ctrl[0] !== 1'b1 || deq_data[63:0] !== 64'hAA) begin errors++; $display("FAIL ctrl_head: got ctrl=%b data=%h expected 1/aa", deq_ctrl[0], deq_data[63:0]); end
        deq_ack = 2'b01;
        cycle();
        deq_ack = 2'b00;
        settle();
        vectors++; if (deq_valid !== 2'b01 || count !== 4'd1) begin errors++; $display("FAIL ctrl_next_valid: got %b count=%0d expected 01/1", deq_valid, count); end
        vectors++; if (deq_data[63:0] !== 64'hBB || deq_ctrl[0] !== 1'b0) begin errors++; $display("FAIL ctrl_next_data: got %h ctrl=%b expected bb/0", deq_data[63:0], deq_ctrl[0]); end
        deq_ack = 2'b01;
        cycle();
        deq_ack = 2'b00;
        settle();
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL ctrl_drain: got empty=%b expected 1", empty); end
        $display("test_ctrl_flow: empty=%b", empty);
    endtask

    task automatic test_wrap();
        do_flush();
        for (int i = 0; i < 7; i++) begin
            enq_valid = 2'b01;
            enq_data  = {64'h0, 64'(32'h100 + i)};
            cycle();
            enq_valid = 2'b00;
            settle();
            vectors++; if (deq_valid !== 2'b01 || deq_data[63:0] !== 64'(32'h100 + i)) begin errors++; $display("FAIL wrap_step[%0d]: got %b/%h expected 01/%h", i, deq_valid, deq_data[63:0], 32'h100 + i); end
            deq_ack = 2'b01;
            cycle();
            deq_ack = 2'b00;
        end
        enq_valid = 2'b11;
        enq_data  = {64'hC1, 64'hC0};
        settle();
        vectors++; if (enq_ack !== 2'b11) begin errors++; $display("FAIL wrap_enq_ack: got %b expected 11", enq_ack); end
        cycle();
        enq_valid = 2'b00;
        settle();
        vectors++; if (count !== 4'd2 || deq_valid !== 2'b11) begin errors++; $display("FAIL wrap_state: got count=%0d valid=%b expected 2/11", count, deq_valid); end
        vectors++; if (deq_data !== {64'hC1, 64'hC0}) begin errors++; $display("FAIL wrap_data: got %h expected c1/c0", deq_data); end
        deq_ack = 2'b11;
        cycle();
        deq_ack = 2'b00;
        settle();
        vectors++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL wrap_drain: got empty=%b count=%0d expected 1/0", empty, count); end
        $display("test_wrap: count=%0d", count);
    endtask

    task automatic test_flush();
        enq_data  = {64'h22, 64'h11};
        enq_valid = 2'b11;
        cycle();
        cycle();
        enq_valid = 2'b01;
        cycle();
        enq_valid = 2'b00;
        settle();
        vectors++; if (count !== 4'd5) begin errors++; $display("FAIL flush_setup: got %0d expected 5", count); end
        flush     = 1'b1;
        enq_valid = 2'b11;
        deq_ack   = 2'b11;
        settle();
        vectors++; if (enq_ack !== 2'b00) begin errors++; $display("FAIL flush_enq_ack: got %b expected 00", enq_ack); end
        cycle();
        flush     = 1'b0;
        enq_valid = 2'b00;
        deq_ack   = 2'b00;
        settle();
        vectors++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_state: got count=%0d empty=%b expected 0/1", count, empty); end
        vectors++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_deq_valid: got %b expected 00", deq_valid); end
        $display("test_flush: count=%0d", count);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        enq_data  = '0;
        enq_valid = '0;
        enq_ctrl  = '0;
        deq_ack   = '0;
        test_reset();
        test_fill_full();
        test_gap();
        test_ctrl_flow();
        test_wrap();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
